cory_sbd_rrarb: RTL and testbench

- Round-robin arbiter sharing one valid/ready downstream channel among N start/busy/done requesters.
- Each requester pulses start and sees busy until its request has handshaken downstream, then receives a one-cycle done.
- Sits between several sequencing blocks and a single shared consumer. Sustains one grant per cycle.

---
 rtl/cory_sbd_rrarb.sv | 162 ++++++++++++++++
 tb/tb_cory_sbd_rrarb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cory_sbd_rrarb.sv
// Round-robin arbiter: N start/busy/done requesters share one valid/ready
// downstream channel, one grant per cycle with back-to-back hand-off.
//
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   i_start[N]  : per-requester start pulse
//   o_busy[N]   : request accepted and not yet handshaken
//   o_done[N]   : one-cycle pulse in the handshake cycle of requester i
//   i_clr_err   : clears all sticky error bits
//   o_err[N]    : sticky, requester restarted while already busy
//   o_v, o_id   : downstream valid and granted index (registered)
//   i_r         : downstream ready
module cory_sbd_rrarb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_start,
    output logic [N-1:0]  o_busy,
    output logic [N-1:0]  o_done,
    input  logic          i_clr_err,
    output logic [N-1:0]  o_err,
    output logic          o_v,
    output logic [IW-1:0] o_id,
    input  logic          i_r
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  err_q, err_d;
    logic          v_q, v_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          hs;
    logic [N-1:0]  id_oh;
    logic [N-1:0]  done;
    logic [N-1:0]  req;
    logic [IW-1:0] base;
    logic          arb_en;
    logic          found;
    logic [IW-1:0] win;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
        if (x == IW'(N - 1)) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    // Rotate the request vector so bit 0 is the base position, then take
    // the first set bit; returns {found, index}.
    function automatic logic [IW:0] pick(
        input logic [N-1:0]  r,
        input logic [IW-1:0] b
    );
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [IW:0]    sum;
        logic           f;
        logic [IW-1:0]  idx;
        dbl = {r, r} >> b;
        rot = dbl[N-1:0];
        f   = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!f && rot[0]) begin
                f   = 1'b1;
                sum = {1'b0, b} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
            end
            rot = rot >> 1;
        end
        return {f, idx};
    endfunction

    always_comb begin
        hs     = v_q & i_r;
        id_oh  = ONE << id_q;
        done   = id_oh & {N{hs}};
        // A start in its own completion cycle re-arms the request.
        pend_d = (pend_q & ~done) | i_start;
        // A fresh error outranks a simultaneous clear.
        err_d  = (i_clr_err ? '0 : err_q) | (i_start & pend_q & ~done);

        state_d = state_q;
        v_d     = v_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        req     = '0;
        base    = ptr_q;
        arb_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req    = pend_q;
                base   = ptr_q;
                arb_en = 1'b1;
            end
            S_GRANT: begin
                if (hs) begin
                    // Only the completing requester's restart is visible
                    // now; other new starts wait until pending is set.
                    req    = (pend_q & ~id_oh) | (i_start & id_oh);
                    base   = nxt(id_q);
                    arb_en = 1'b1;
                end
            end
            default: ;
        endcase

        {found, win} = pick(req, base);

        if (arb_en) begin
            if (found) begin
                state_d = S_GRANT;
                v_d     = 1'b1;
                id_d    = win;
                ptr_d   = nxt(win);
            end else begin
                state_d = S_IDLE;
                v_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            err_q   <= '0;
            v_q     <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            v_q     <= v_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_busy = pend_q;
    assign o_done = done;
    assign o_err  = err_q;
    assign o_v    = v_q;
    assign o_id   = id_q;

endmodule

// File: tb/tb_cory_sbd_rrarb.sv
// Scoreboard bench for cory_sbd_rrarb: stimulus queues expected grant ids,
// a negedge monitor pops and checks them on every downstream handshake.
module tb_cory_sbd_rrarb;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  i_start = '0;
    logic          i_clr_err = 1'b0;
    logic          i_r = 1'b0;
    logic [N-1:0]  o_busy;
    logic [N-1:0]  o_done;
    logic [N-1:0]  o_err;
    logic          o_v;
    logic [IW-1:0] o_id;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    cory_sbd_rrarb #(.N(N), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .i_clr_err (i_clr_err),
        .o_err     (o_err),
        .o_v       (o_v),
        .o_id      (o_id),
        .i_r       (i_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every handshake must match the next queued grant.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (o_v === 1'b1 && i_r === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL grant_unexpected: got id %0d expected none",
                             o_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(o_id), 32'(e));
                    chk("grant_done", 32'(o_done), 32'd1 << e);
                end
            end else begin
                chk("idle_done", 32'(o_done), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        smp();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_v", 32'(o_v), 0);
        chk("rst_id", 32'(o_id), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_done", 32'(o_done), 0);

        // Single request, latency start->busy->valid
        step(); i_start = 4'b0100; i_r = 1'b1; exp_q.push_back(2);
        step(); i_start = '0;
        smp();
        chk("t1_busy", 32'(o_busy), 32'h4);
        chk("t1_v_early", 32'(o_v), 0);
        step(); smp();
        chk("t1_v", 32'(o_v), 1);
        chk("t1_id", 32'(o_id), 2);
        chk("t1_done", 32'(o_done), 32'h4);
        step(); smp();
        chk("t1_busy_clr", 32'(o_busy), 0);
        chk("t1_v_clr", 32'(o_v), 0);

        // Fairness: all four, then 1011 with ptr back at 0
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        step(); i_start = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(2); exp_q.push_back(3);
        step(); i_start = '0;
        smp();
        chk("t2_busy", 32'(o_busy), 32'hF);
        for (int k = 0; k < 4; k++) begin
            step(); smp();
            chk("t2_v", 32'(o_v), 1);
            chk("t2_id", 32'(o_id), 32'(k));
        end
        step(); smp();
        chk("t2_v_end", 32'(o_v), 0);
        step(); i_start = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        step(); i_start = '0;
        repeat (3) step();
        step(); smp();
        chk("t2b_v_end", 32'(o_v), 0);
        chk("t2b_busy", 32'(o_busy), 0);

        // Backpressure
        step(); i_r = 1'b0; i_start = 4'b0010; exp_q.push_back(1);
        step(); i_start = '0;
        for (int k = 0; k < 5; k++) begin
            step(); smp();
            chk("t3_v_hold", 32'(o_v), 1);
            chk("t3_id_hold", 32'(o_id), 1);
        end
        step(); i_r = 1'b1;
        smp();
        chk("t3_done", 32'(o_done), 32'h2);
        step(); smp();
        chk("t3_v_end", 32'(o_v), 0);
        chk("t3_busy_end", 32'(o_busy), 0);

        // Error on restart while busy, restart on own handshake, clear
        step(); i_r = 1'b0; i_start = 4'b0010; exp_q.push_back(1);
        step(); i_start = 4'b0010;
        smp();
        chk("t4_busy", 32'(o_busy), 32'h2);
        chk("t4_err_pre", 32'(o_err), 0);
        step(); i_start = '0;
        smp();
        chk("t4_err", 32'(o_err), 32'h2);
        chk("t4_v", 32'(o_v), 1);
        chk("t4_id", 32'(o_id), 1);
        step(); i_r = 1'b1; i_start = 4'b0010; exp_q.push_back(1);
        smp();
        chk("t4_done1", 32'(o_done), 32'h2);
        step(); i_start = '0;
        smp();
        chk("t4_v2", 32'(o_v), 1);
        chk("t4_id2", 32'(o_id), 1);
        chk("t4_busy2", 32'(o_busy), 32'h2);
        chk("t4_err_keep", 32'(o_err), 32'h2);
        step(); i_clr_err = 1'b1;
        smp();
        chk("t4_v_end", 32'(o_v), 0);
        chk("t4_busy_end", 32'(o_busy), 0);
        step(); i_clr_err = 1'b0;
        smp();
        chk("t4_err_clr", 32'(o_err), 0);

        // Error beats clear, then async reset mid-grant
        step(); i_r = 1'b0; i_start = 4'b0101;
        step(); i_start = 4'b0100; i_clr_err = 1'b1;
        smp();
        chk("t5_busy", 32'(o_busy), 32'h5);
        step(); i_start = '0; i_clr_err = 1'b0;
        smp();
        chk("t5_err_wins", 32'(o_err), 32'h4);
        chk("t5_v", 32'(o_v), 1);
        chk("t5_id", 32'(o_id), 2);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_v", 32'(o_v), 0);
        chk("t5_rst_busy", 32'(o_busy), 0);
        chk("t5_rst_err", 32'(o_err), 0);
        chk("t5_rst_done", 32'(o_done), 0);
        step();
        step(); reset = 1'b0; i_r = 1'b1;
        repeat (4) step();
        smp();
        chk("t5_post_busy", 32'(o_busy), 0);
        chk("t5_post_v", 32'(o_v), 0);

        // Starvation: requester 0 restarts on its handshake, 3 still served
        step(); i_start = 4'b1001;
        exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
        step(); i_start = '0;
        step(); i_start = 4'b0001;
        smp();
        chk("t6_id0", 32'(o_id), 0);
        step(); i_start = '0;
        smp();
        chk("t6_id3", 32'(o_id), 3);
        chk("t6_err", 32'(o_err), 0);
        step(); smp();
        chk("t6_id0b", 32'(o_id), 0);
        step(); smp();
        chk("t6_v_end", 32'(o_v), 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            step();
        end
        chk("queue_drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
